// File: rtl/igen_pipe.sv
// Registered immediate generator with a two-entry skid buffer and flush.
// Optional macro IGEN_CSR_EN adds CSR immediate decode for SYSTEM opcodes.
module igen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     insn_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [31:0]     insn_o,
    output logic [XLEN-1:0] pc_o,
    output logic [2:0]      fmt_o
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IGEN_CSR_EN
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [2:0] FMT_Z     = 3'd6;
`endif

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [31:0]     imm32;
    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            accept;
    logic            handshake;

    state_t          state;
    logic [XLEN-1:0] skid_imm;
    logic [31:0]     skid_insn;
    logic [XLEN-1:0] skid_pc;
    logic [2:0]      skid_fmt;

    assign opcode   = insn_i[6:0];
    assign funct3   = insn_i[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Every immediate fits in 32 bits sign-extended; values that must be
    // zero-extended (shamt, zimm, CSR address) always leave bit 31 clear.
    always_comb begin
        imm32   = '0;
        dec_fmt = FMT_NONE;
        case (opcode)
            OP_IMM: begin
                dec_fmt = FMT_I;
                if (is_shift)
                    imm32 = (XLEN == 64) ? {26'd0, insn_i[25:20]} : {27'd0, insn_i[24:20]};
                else
                    imm32 = {{20{insn_i[31]}}, insn_i[31:20]};
            end
            OP_IMM_32: begin
                if (XLEN == 64) begin
                    dec_fmt = FMT_I;
                    imm32   = is_shift ? {27'd0, insn_i[24:20]} : {{20{insn_i[31]}}, insn_i[31:20]};
                end
            end
            OP_LOAD, OP_JALR: begin
                dec_fmt = FMT_I;
                imm32   = {{20{insn_i[31]}}, insn_i[31:20]};
            end
            OP_STORE: begin
                dec_fmt = FMT_S;
                imm32   = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
            end
            OP_BRANCH: begin
                dec_fmt = FMT_B;
                imm32   = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt = FMT_U;
                imm32   = {insn_i[31:12], 12'd0};
            end
            OP_JAL: begin
                dec_fmt = FMT_J;
                imm32   = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
            end
`ifdef IGEN_CSR_EN
            OP_SYSTEM: begin
                if (funct3[2] && (funct3[1:0] != 2'b00)) begin
                    dec_fmt = FMT_Z;
                    imm32   = {27'd0, insn_i[19:15]};
                end else begin
                    dec_fmt = FMT_I;
                    imm32   = {20'd0, insn_i[31:20]};
                end
            end
`endif
            default: begin
                imm32   = '0;
                dec_fmt = FMT_NONE;
            end
        endcase
    end

    assign dec_imm   = XLEN'($signed(imm32));
    assign accept    = in_valid_i && in_ready_o && !flush_i;
    assign handshake = out_valid_o && out_ready_i;

    // in_ready_o is the registered inverse of SKID occupancy, so it never
    // depends combinationally on out_ready_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            imm_o       <= '0;
            insn_o      <= '0;
            pc_o        <= '0;
            fmt_o       <= FMT_NONE;
            skid_imm    <= '0;
            skid_insn   <= '0;
            skid_pc     <= '0;
            skid_fmt    <= FMT_NONE;
        end else if (flush_i) begin
            state       <= EMPTY;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        imm_o       <= dec_imm;
                        insn_o      <= insn_i;
                        pc_o        <= pc_i;
                        fmt_o       <= dec_fmt;
                        out_valid_o <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (handshake && accept) begin
                        imm_o  <= dec_imm;
                        insn_o <= insn_i;
                        pc_o   <= pc_i;
                        fmt_o  <= dec_fmt;
                    end else if (handshake) begin
                        out_valid_o <= 1'b0;
                        state       <= EMPTY;
                    end else if (accept) begin
                        skid_imm   <= dec_imm;
                        skid_insn  <= insn_i;
                        skid_pc    <= pc_i;
                        skid_fmt   <= dec_fmt;
                        in_ready_o <= 1'b0;
                        state      <= FULL;
                    end
                end
                FULL: begin
                    if (handshake) begin
                        imm_o      <= skid_imm;
                        insn_o     <= skid_insn;
                        pc_o       <= skid_pc;
                        fmt_o      <= skid_fmt;
                        in_ready_o <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_igen_pipe.sv
// Bench for igen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
// Expected entries are queued on acceptance and compared on output handshake.
module tb_igen_pipe;

    typedef struct packed {
        logic [63:0] imm64;
        logic [31:0] imm32;
        logic [2:0]  fmt64;
        logic [2:0]  fmt32;
        logic [31:0] insn;
        logic [63:0] pc64;
        logic [31:0] pc32;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] insn;
    logic [63:0] pc;

    logic        rdy32, ov32, rdy64, ov64;
    logic [31:0] imm32, insn32, pc32;
    logic [63:0] imm64, pc64;
    logic [31:0] insn64;
    logic [2:0]  fmt32, fmt64;

    entry_t exp_q[$];
    entry_t got_q[$];
    int     checks = 0;
    int     errors = 0;
    int     acc_count = 0;

`ifdef IGEN_CSR_EN
    localparam logic [63:0] CSR_IMM = 64'h5;
    localparam logic [2:0]  CSR_FMT = 3'd6;
`else
    localparam logic [63:0] CSR_IMM = 64'h0;
    localparam logic [2:0]  CSR_FMT = 3'd0;
`endif

    always #5 clk = ~clk;

    igen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy32),
        .insn_i(insn), .pc_i(pc[31:0]), .out_valid_o(ov32), .out_ready_i(out_ready),
        .imm_o(imm32), .insn_o(insn32), .pc_o(pc32), .fmt_o(fmt32)
    );

    igen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy64),
        .insn_i(insn), .pc_i(pc), .out_valid_o(ov64), .out_ready_i(out_ready),
        .imm_o(imm64), .insn_o(insn64), .pc_o(pc64), .fmt_o(fmt64)
    );

    // Reference decode written straight from the instruction formats; returns {fmt, imm}.
    function automatic logic [66:0] model(input logic [31:0] w, input bit x64);
        logic [63:0] v;
        logic [2:0]  f;
        logic [63:0] s12;
        logic [2:0]  f3;
        s12 = {{52{w[31]}}, w[31:20]};
        f3  = w[14:12];
        v   = 64'd0;
        f   = 3'd0;
        case (w[6:0])
            7'h13: begin
                f = 3'd1;
                if (f3 == 3'd1 || f3 == 3'd5) v = x64 ? {58'd0, w[25:20]} : {59'd0, w[24:20]};
                else v = s12;
            end
            7'h1B: if (x64) begin
                f = 3'd1;
                v = (f3 == 3'd1 || f3 == 3'd5) ? {59'd0, w[24:20]} : s12;
            end
            7'h67, 7'h03: begin f = 3'd1; v = s12; end
            7'h23: begin f = 3'd2; v = {{52{w[31]}}, w[31:25], w[11:7]}; end
            7'h63: begin f = 3'd3; v = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0}; end
            7'h37, 7'h17: begin f = 3'd4; v = {{32{w[31]}}, w[31:12], 12'd0}; end
            7'h6F: begin f = 3'd5; v = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; end
`ifdef IGEN_CSR_EN
            7'h73: begin
                if (f3 >= 3'd5) begin f = 3'd6; v = {59'd0, w[19:15]}; end
                else begin f = 3'd1; v = {52'd0, w[31:20]}; end
            end
`endif
            default: begin f = 3'd0; v = 64'd0; end
        endcase
        return {f, x64 ? v : {32'd0, v[31:0]}};
    endfunction

    function automatic entry_t make_entry(input logic [31:0] w, input logic [63:0] p);
        entry_t      e;
        logic [66:0] m64, m32;
        m64     = model(w, 1'b1);
        m32     = model(w, 1'b0);
        e.imm64 = m64[63:0];
        e.fmt64 = m64[66:64];
        e.imm32 = m32[31:0];
        e.fmt32 = m32[66:64];
        e.insn  = w;
        e.pc64  = p;
        e.pc32  = p[31:0];
        return e;
    endfunction

    // One clock: log handshakes and acceptances seen before the edge, then advance.
    task automatic step();
        entry_t g;
        if (ov32 && out_ready && !flush) begin
            g = '{imm64: imm64, imm32: imm32, fmt64: fmt64, fmt32: fmt32,
                  insn: insn32, pc64: pc64, pc32: pc32};
            got_q.push_back(g);
        end
        if (flush) exp_q.delete();
        else if (in_valid && rdy32) begin
            exp_q.push_back(make_entry(insn, pc));
            acc_count++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        insn = '0; pc = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (ov32 !== 1'b0 || rdy32 !== 1'b1 || ov64 !== 1'b0 || rdy64 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_handshake: ov32=%b rdy32=%b ov64=%b rdy64=%b, required ov=0 rdy=1",
                     ov32, rdy32, ov64, rdy64);
        end
        checks++;
        if ({imm32, insn32, pc32, fmt32, imm64, pc64, fmt64} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: imm32=%h insn=%h pc32=%h fmt32=%0d imm64=%h pc64=%h fmt64=%0d, required 0",
                     imm32, insn32, pc32, fmt32, imm64, pc64, fmt64);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        logic [31:0] t_insn [10] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'hFE006CE3,
                                     32'hABCDE2B7, 32'h43F0D093, 32'hFFF0809B, 32'h3002D073,
                                     32'h8000006F, 32'h0000007F};
        logic [31:0] t_imm32 [10] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFF8,
                                      32'hABCDE000, 32'h0000001F, 32'h0, CSR_IMM[31:0],
                                      32'hFFF00000, 32'h0};
        logic [2:0]  t_fmt32 [10] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd1, 3'd0, CSR_FMT, 3'd5, 3'd0};
        logic [63:0] t_imm64 [10] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                                      64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFABCDE000, 64'h3F,
                                      64'hFFFFFFFFFFFFFFFF, CSR_IMM, 64'hFFFFFFFFFFF00000, 64'h0};
        logic [2:0]  t_fmt64 [10] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd1, 3'd1, CSR_FMT, 3'd5, 3'd0};
        entry_t g, e;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            insn     = t_insn[i];
            pc       = {$urandom, $urandom};
            step();
            checks++;
            if (ov32 !== 1'b1 || ov64 !== 1'b1 || imm32 !== t_imm32[i] || fmt32 !== t_fmt32[i] ||
                imm64 !== t_imm64[i] || fmt64 !== t_fmt64[i]) begin
                errors++;
                $display("[TB] FAIL stream_%0d insn=%h: ov=%b/%b imm32=%h fmt32=%0d imm64=%h fmt64=%0d, required ov=1 imm32=%h fmt32=%0d imm64=%h fmt64=%0d",
                         i, t_insn[i], ov32, ov64, imm32, fmt32, imm64, fmt64,
                         t_imm32[i], t_fmt32[i], t_imm64[i], t_fmt64[i]);
            end
        end
        in_valid = 1'b0;
        repeat (3) step();
        checks++;
        if (got_q.size() != 10 || exp_q.size() != 10) begin
            errors++;
            $display("[TB] FAIL stream_count: delivered=%0d accepted=%0d, required 10", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL stream_sb: got %h, required %h", g, e);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3] = '{32'h00500113, 32'h00A12223, 32'h0100006F};
        int     acc0;
        entry_t g, e;
        acc0      = acc_count;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            insn = words[i];
            pc   = {32'h0, $urandom};
            step();
        end
        insn = words[2];
        pc   = 64'h1000;
        checks++;
        if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_ready_low: rdy32=%b rdy64=%b, required 0", rdy32, rdy64);
        end
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ov32 !== 1'b1 || insn32 !== words[0] || insn64 !== words[0]) begin
                errors++;
                $display("[TB] FAIL bp_out_stable_%0d: ov=%b insn32=%h insn64=%h, required ov=1 insn=%h",
                         c, ov32, insn32, insn64, words[0]);
            end
            step();
        end
        checks++;
        if (acc_count - acc0 != 2) begin
            errors++;
            $display("[TB] FAIL bp_accepted: accepted=%0d, required 2", acc_count - acc0);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 8 && in_valid; c++) begin
            if (acc_count - acc0 == 3) in_valid = 1'b0;
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("[TB] FAIL bp_delivered: delivered=%0d, required 3", got_q.size());
        end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL bp_sb: got extra %h, required none", g);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("[TB] FAIL bp_sb: got %h, required %h", g, e);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_flush();
        int acc0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        insn = 32'h00100093; pc = 64'h2000; step();
        insn = 32'h00200113; pc = 64'h2004; step();
        acc0     = acc_count;
        flush    = 1'b1;
        insn     = 32'h00300193;
        pc       = 64'h2008;
        step();
        flush    = 1'b0;
        checks++;
        if (ov32 !== 1'b0 || ov64 !== 1'b0 || rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_state: ov=%b/%b rdy=%b/%b, required ov=0 rdy=1", ov32, ov64, rdy32, rdy64);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        checks++;
        if (got_q.size() != 0 || acc_count != acc0) begin
            errors++;
            $display("[TB] FAIL flush_discard: delivered=%0d extra_accepts=%0d, required 0 and 0",
                     got_q.size(), acc_count - acc0);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        insn = 32'hFFF00093; pc = 64'hFFFF_0000_1234_5678; step();
        insn = 32'hABCDE2B7; pc = 64'h0000_0000_8765_4320; step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ov32 !== 1'b0 || ov64 !== 1'b0 || rdy32 !== 1'b1 || rdy64 !== 1'b1 ||
            {imm32, insn32, pc32, fmt32, imm64, insn64, pc64, fmt64} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_async: ov=%b/%b rdy=%b/%b imm32=%h imm64=%h insn=%h pc64=%h fmt=%0d/%0d, required reset values",
                     ov32, ov64, rdy32, rdy64, imm32, imm64, insn32, pc64, fmt32, fmt64);
        end
        got_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/igen_pipe.md
# igen_pipe

Registered, parametrised immediate generator for the decode stage. Accepts raw instructions with their PC over a valid/ready handshake and produces an XLEN-wide immediate and a format code. Instruction and PC pass through alongside. A two-entry skid buffer gives full throughput under backpressure, and a flush input discards in-flight entries on redirect. It supersedes the combinational `igen` for pipelined cores.

## Interface
- `XLEN`, 32: datapath width; legal values 32 or 64.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  discard all buffered entries; block acceptance this cycle.
- `in_valid_i`  in  1  upstream instruction valid.
- `in_ready_o`  out  1  block can accept.
- `insn_i`  in  32  instruction word.
- `pc_i`  in  XLEN  instruction PC.
- `out_valid_o`  out  1  output entry valid.
- `out_ready_i`  in  1  downstream accepts.
- `imm_o`  out  XLEN  generated immediate.
- `insn_o`  out  32  instruction word passed through.
- `pc_o`  out  XLEN  PC passed through.
- `fmt_o`  out  3  format code: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).

## Operation
- Immediate decode is combinational on `insn_i`, captured on acceptance; opcode = `insn[6:0]`, funct3 = `insn[14:12]`.
  - OP-IMM 0010011, JALR 1100111, LOAD 0000011 → I: sign-extend `insn[31:20]`.
  - OP-IMM with funct3 001/101 → shamt zero-extended. XLEN=32: `insn[24:20]`; XLEN=64: `insn[25:20]`. funct7 is not part of imm.
  - XLEN=64 only: OP-IMM-32 0011011 → I; shift shamt is `insn[24:20]`. At XLEN=32 this opcode is fmt 0.
  - STORE 0100011 → S: sign-extend `{insn[31:25],insn[11:7]}`.
  - BRANCH 1100011 → B: sign-extend `{insn[31],insn[7],insn[30:25],insn[11:8],0}` for all funct3, including bltu/bgeu.
  - LUI 0110111, AUIPC 0010111 → U: `{insn[31:12],12'b0}`, sign-extended from bit 31 when XLEN=64.
  - JAL 1101111 → J: sign-extend `{insn[31],insn[19:12],insn[20],insn[30:21],0}`.
  - Any other opcode → imm 0, fmt 0. The entry still flows through; it is never dropped.
- Buffer: an output register (OUT) plus a skid register (SKID). Each holds valid, imm, insn, pc and fmt.
  - `in_ready_o` = !SKID.valid, registered, so it has no combinational path from `out_ready_i`.
  - Accept when `in_valid_i && in_ready_o && !flush_i`.
  - Output handshake completes when `out_valid_o && out_ready_i`.
- Buffer states:
  - EMPTY (OUT, SKID invalid): an accept loads OUT → ONE.
  - ONE, no handshake: an accept loads SKID → FULL.
  - ONE, handshake: an accept reloads OUT and state stays ONE; with no accept → EMPTY.
  - FULL (in_ready low), no handshake: state holds.
  - FULL, handshake: SKID moves to OUT → ONE.
- `flush_i` high: OUT.valid and SKID.valid clear at the next edge and any input is ignored. Flush has priority over simultaneous accept and handshake.

## Timing
- Latency 1 cycle: an entry accepted at edge N is visible on the outputs after edge N.
- Throughput: one entry per cycle while `out_ready_i` is high.
- OUT data holds stable while `out_valid_o && !out_ready_i`.
- Reset (async assert, sync release): `out_valid_o`=0, `in_ready_o`=1, `imm_o`/`insn_o`/`pc_o`=0, `fmt_o`=0, SKID cleared.
- Reset asserted mid-transfer discards all entries immediately.
- Outputs are driven only from registers.

## Configuration
- `IGEN_CSR_EN` defined: SYSTEM 1110011 with funct3 101/110/111 (csrrwi/csrrsi/csrrci) gives imm = zero-extended `insn[19:15]` and fmt 6. Other SYSTEM funct3 give imm = zero-extended `insn[31:20]` (CSR address) and fmt 1.
- `IGEN_CSR_EN` undefined: SYSTEM is fmt 0, imm 0. Encoding 6 is never produced.

## Test plan
- XLEN=32, `out_ready_i`=1; stream 0xFFF00093 (addi -1) and 0xFE112E23 (sw -4). Required: imm 0xFFFFFFFF fmt 1, then 0xFFFFFFFC fmt 2, on consecutive cycles, each 1 cycle after acceptance.
- 0xFE000CE3 (beq -8) and 0xFE006CE3 (bltu -8). Required: both imm 0xFFFFFFF8 fmt 3.
- XLEN=64, 0xABCDE2B7 (lui). Required: imm 0xFFFFFFFFABCDE000 fmt 4. Also 0x43F0D093 (srai 63). Required: imm 0x3F.
- Hold `out_ready_i`=0 and offer 3 instructions back-to-back. Required: 2 accepted, `in_ready_o` low on the third cycle, and OUT stable. Then raise `out_ready_i`. Required: entries delivered in order, no loss or duplication.
- FULL state plus `flush_i` pulse with `in_valid_i`=1. Required: `out_valid_o`=0 next cycle, `in_ready_o`=1, and the offered instruction is not accepted.
- 0x3002D073 (csrrwi 0x300, 5). Required: imm 0x5 fmt 6 with `IGEN_CSR_EN`; imm 0 fmt 0 without it.
- Assert `rst_n`=0 while in FULL. Required: all outputs take their reset values immediately, without waiting for a clock edge.
